// File: rtl/oai31_bist_pkg.sv
// oai31_bist_pkg: shared state encoding and vector helpers for the oai31 arc BIST.
// Optional coverage feature (macro OAI31_ARC_COV_EN) lives in oai31_arc_bist.
package oai31_bist_pkg;

   // Vectors in one exhaustive sweep of the four cell inputs
   localparam int NVEC = 16;

   // FSM states; prefixed so they cannot collide with the top-level DONE port
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DRIVE  = 3'd1,
      ST_SETTLE = 3'd2,
      ST_SAMPLE = 3'd3,
      ST_DONE   = 3'd4
   } bist_state_t;

   // 4-bit reflected Gray code of an index
   function automatic logic [3:0] gray4(input logic [3:0] i);
      return i ^ {1'b0, i[3:1]};
   endfunction

   // Ideal oai31 response for {A1,A2,A3,B}: ZN = ~((A1|A2|A3)&B)
   function automatic logic oai31_exp(input logic [3:0] vec);
      return ~((vec[3] | vec[2] | vec[1]) & vec[0]);
   endfunction

endpackage

// File: rtl/oai31_gray_seq.sv
// oai31_gray_seq: vector index and sweep counter for the oai31 BIST.
// Presents the current Gray vector, the pin that changed from the previous
// vector (wrapping 1000 -> 0000 between sweeps), and a last-vector flag.
module oai31_gray_seq
   import oai31_bist_pkg::*;
#(
   parameter int SWEEPS = 1
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_clear,
   input  logic       i_advance,
   output logic [3:0] o_vec,
   output logic [3:0] o_changed,
   output logic       o_last
);

   localparam logic [3:0] IDX_LAST   = 4'(NVEC - 1);
   localparam logic [7:0] SWEEP_LAST = 8'(SWEEPS - 1);

   logic [3:0] r_idx;
   logic [7:0] r_sweep;
   logic [3:0] w_prev_idx;

   // Step the vector index, carrying into the sweep count at the end of each sweep
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_idx   <= 4'd0;
         r_sweep <= 8'd0;
      end else if (i_clear) begin
         r_idx   <= 4'd0;
         r_sweep <= 8'd0;
      end else if (i_advance) begin
         if (r_idx == IDX_LAST) begin
            r_idx   <= 4'd0;
            r_sweep <= r_sweep + 8'd1;
         end else begin
            r_idx   <= r_idx + 4'd1;
         end
      end
   end

   // Index 0 wraps back to 15 so the between-sweep step is reported as well
   assign w_prev_idx = r_idx - 4'd1;
   assign o_vec      = gray4(r_idx);
   assign o_changed  = gray4(r_idx) ^ gray4(w_prev_idx);
   assign o_last     = (r_idx == IDX_LAST) && (r_sweep == SWEEP_LAST);

endmodule

// File: rtl/oai31_arc_bist.sv
// oai31_arc_bist: self-test driver/checker for one oai31 cell.
// Sweeps {A1,A2,A3,B} through a 4-bit Gray code, waits SETTLE_CYC cycles,
// samples ZN and counts mismatches against ~((A1|A2|A3)&B).
// Optional macro OAI31_ARC_COV_EN adds ARC_COV[7:0] conditional-arc coverage
// and makes PASS require full coverage.
module oai31_arc_bist
   import oai31_bist_pkg::*;
#(
   parameter int SETTLE_CYC = 2,
   parameter int ERR_W      = 5,
   parameter int SWEEPS     = 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic             ZN,
   output logic             A1,
   output logic             A2,
   output logic             A3,
   output logic             B,
   output logic             BUSY,
   output logic             DONE,
   output logic             PASS,
   output logic [ERR_W-1:0] ERR_CNT,
   output logic [3:0]       FAIL_VEC
`ifdef OAI31_ARC_COV_EN
   ,
   output logic [7:0]       ARC_COV
`endif
);

   localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYC - 1);
   localparam logic [ERR_W-1:0] ERR_ZERO    = {ERR_W{1'b0}};
   localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

   bist_state_t      r_state;
   bist_state_t      w_state_nxt;
   logic [3:0]       r_settle;
   logic [3:0]       w_settle_nxt;
   logic [3:0]       r_pins;
   logic [3:0]       w_pins_nxt;
   logic [ERR_W-1:0] r_err;
   logic [ERR_W-1:0] w_err_nxt;
   logic [3:0]       r_fail_vec;
   logic [3:0]       w_fail_vec_nxt;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;
   logic             w_pass_nxt;
   logic             w_start_acc;
   logic             w_clear;
   logic             w_advance;
   logic             w_mismatch;
   logic [3:0]       w_vec;
   logic             w_last;

`ifdef OAI31_ARC_COV_EN
   logic [3:0]       w_changed;
   logic [7:0]       r_cov;
   logic [7:0]       w_cov_nxt;
   logic [7:0]       w_cov_set;
   logic             r_prev_zn;
   logic             w_prev_zn_nxt;
   logic             r_prev_ok;
   logic             w_prev_ok_nxt;
   logic             w_toggle;
   logic             w_b_arc;
   logic             w_a_arc;
`else
   logic [3:0]       w_changed_unused;
`endif

   oai31_gray_seq #(
      .SWEEPS(SWEEPS)
   ) u_seq (
      .i_clk    (CLK),
      .i_rst    (RST),
      .i_clear  (w_clear),
      .i_advance(w_advance),
      .o_vec    (w_vec),
`ifdef OAI31_ARC_COV_EN
      .o_changed(w_changed),
`else
      .o_changed(w_changed_unused),
`endif
      .o_last   (w_last)
   );

   // START only counts when no test is running; the final SAMPLE is still busy
   assign w_start_acc = START && ((r_state == ST_IDLE) || (r_state == ST_DONE));

   // X or Z on ZN must count as a failure, hence the case-equality compare
   assign w_mismatch = !(ZN === oai31_exp(r_pins));

   // Next-state, pin drive and error bookkeeping
   always_comb begin
      w_state_nxt    = r_state;
      w_settle_nxt   = r_settle;
      w_pins_nxt     = r_pins;
      w_err_nxt      = r_err;
      w_fail_vec_nxt = r_fail_vec;
      w_clear        = 1'b0;
      w_advance      = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (w_start_acc) begin
               w_state_nxt    = ST_DRIVE;
               w_clear        = 1'b1;
               w_err_nxt      = ERR_ZERO;
               w_fail_vec_nxt = 4'b0000;
            end else begin
               w_state_nxt = r_state;
            end
         end
         ST_DRIVE: begin
            w_pins_nxt   = w_vec;
            w_settle_nxt = 4'd0;
            w_state_nxt  = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (r_settle == SETTLE_LAST) begin
               w_state_nxt = ST_SAMPLE;
            end else begin
               w_settle_nxt = r_settle + 4'd1;
            end
         end
         ST_SAMPLE: begin
            if (w_mismatch) begin
               // error count of zero marks the first mismatch of this test
               w_fail_vec_nxt = (r_err == ERR_ZERO) ? r_pins : r_fail_vec;
               w_err_nxt      = (r_err == ERR_MAX) ? r_err : (r_err + {{(ERR_W-1){1'b0}}, 1'b1});
            end else begin
               w_err_nxt = r_err;
            end
            if (w_last) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_advance   = 1'b1;
               w_state_nxt = ST_DRIVE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

`ifdef OAI31_ARC_COV_EN
   // A ZN toggle between consecutive samples of one test marks the arc of the flipped pin
   assign w_toggle  = r_prev_ok && (ZN != r_prev_zn);
   assign w_b_arc   = w_toggle && (w_changed == 4'b0001) && (r_pins[3:1] != 3'b000);
   assign w_a_arc   = w_toggle && (w_changed[3:1] != 3'b000);
   assign w_cov_set = {7'b0000000, w_a_arc} |
                      (w_b_arc ? (8'b00000001 << r_pins[3:1]) : 8'b00000000);

   // Coverage accumulation; cleared by an accepted START
   always_comb begin
      w_cov_nxt     = r_cov;
      w_prev_zn_nxt = r_prev_zn;
      w_prev_ok_nxt = r_prev_ok;
      if (w_start_acc) begin
         w_cov_nxt     = 8'h00;
         w_prev_zn_nxt = 1'b0;
         w_prev_ok_nxt = 1'b0;
      end else if (r_state == ST_SAMPLE) begin
         w_cov_nxt     = r_cov | w_cov_set;
         w_prev_zn_nxt = ZN;
         w_prev_ok_nxt = 1'b1;
      end else begin
         w_cov_nxt = r_cov;
      end
   end

   // Coverage registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_cov     <= 8'h00;
         r_prev_zn <= 1'b0;
         r_prev_ok <= 1'b0;
      end else begin
         r_cov     <= w_cov_nxt;
         r_prev_zn <= w_prev_zn_nxt;
         r_prev_ok <= w_prev_ok_nxt;
      end
   end

   assign w_pass_nxt = (w_state_nxt == ST_DONE) && (w_err_nxt == ERR_ZERO) && (w_cov_nxt == 8'hFF);
   assign ARC_COV    = r_cov;
`else
   assign w_pass_nxt = (w_state_nxt == ST_DONE) && (w_err_nxt == ERR_ZERO);
`endif

   // State, pins, results and status flags
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state    <= ST_IDLE;
         r_settle   <= 4'd0;
         r_pins     <= 4'b0000;
         r_err      <= ERR_ZERO;
         r_fail_vec <= 4'b0000;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_pass     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_settle   <= w_settle_nxt;
         r_pins     <= w_pins_nxt;
         r_err      <= w_err_nxt;
         r_fail_vec <= w_fail_vec_nxt;
         r_busy     <= (w_state_nxt == ST_DRIVE) || (w_state_nxt == ST_SETTLE) ||
                       (w_state_nxt == ST_SAMPLE);
         r_done     <= (w_state_nxt == ST_DONE);
         r_pass     <= w_pass_nxt;
      end
   end

   assign A1       = r_pins[3];
   assign A2       = r_pins[2];
   assign A3       = r_pins[1];
   assign B        = r_pins[0];
   assign BUSY     = r_busy;
   assign DONE     = r_done;
   assign PASS     = r_pass;
   assign ERR_CNT  = r_err;
   assign FAIL_VEC = r_fail_vec;

endmodule
